uart_rx_cfg: RTL

//  Configurable UART receiver: successor to the fixed 8N1 receiver.

---
 rtl/uart_rx_cfg.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronized rx, armed start detection with glitch
// rejection, parity/framing/break checks, and a first-word-fall-through output FIFO.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       overrun,
  output logic       busy
);
  // state  | meaning
  // IDLE   | waiting for a falling edge on rx_s while armed
  // START  | half-bit wait, then confirm start bit is still low
  // DATA   | one sample per bit time, LSB first
  // PAR    | parity bit sample (only reachable when PARITY != 0)
  // STOP   | stop bit samples; push entry on the last one
  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int          PW           = $clog2(FIFO_DEPTH);
  localparam logic [15:0] FULL_BIT     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_BIT     = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  LAST_DATA    = 3'(DATA_BITS - 1);
  localparam logic        LAST_STOP    = 1'(STOP_BITS - 1);
  localparam logic [PW:0] PTR_ONE      = (PW + 1)'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t      state;
  logic        rx_m, rx_s, rx_d;
  logic        armed;
  logic [15:0] arm_cnt, cnt;
  logic [2:0]  bit_idx;
  logic        stop_idx;
  logic [7:0]  shreg;
  logic        par_acc, par_err_q, ferr_acc, any_one;
  logic [PW:0] wr_ptr, rd_ptr;
  logic [9:0]  mem [FIFO_DEPTH];
  logic        tick, push, pop, full, push_ferr, push_brk, wr_ok;
  logic [9:0]  entry, head;

  always_comb begin
    tick       = (cnt == '0);
    push       = (state == STOP) && tick && (stop_idx == LAST_STOP);
    push_ferr  = ferr_acc | ~rx_s;
    push_brk   = push_ferr & ~any_one;
    entry      = {par_err_q, push_ferr, shreg};
    valid      = (wr_ptr != rd_ptr);
    full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    pop        = rd_en && valid;
    wr_ok      = push && (!full || pop);
    head       = valid ? mem[rd_ptr[PW-1:0]] : '0;
    data       = head[7:0];
    frame_err  = head[8];
    parity_err = head[9];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      arm_cnt   <= FULL_BIT;
      armed     <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      par_err_q <= 1'b0;
      ferr_acc  <= 1'b0;
      any_one   <= 1'b0;
      break_det <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_d      <= rx_s;
      break_det <= 1'b0;
      // Line must stay high a full bit time before a start is believed.
      if (!armed) begin
        if (!rx_s)               arm_cnt <= FULL_BIT;
        else if (arm_cnt == '0)  armed   <= 1'b1;
        else                     arm_cnt <= arm_cnt - 16'd1;
      end
      if (state != IDLE) cnt <= tick ? FULL_BIT : cnt - 16'd1;
      case (state)
        IDLE: if (armed && rx_d && !rx_s) begin
          state <= START;
          busy  <= 1'b1;
          cnt   <= HALF_BIT;
        end
        START: if (tick) begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= DATA;
            bit_idx   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            par_err_q <= 1'b0;
            ferr_acc  <= 1'b0;
            any_one   <= 1'b0;
          end
        end
        DATA: if (tick) begin
          shreg[bit_idx] <= rx_s;
          par_acc        <= par_acc ^ rx_s;
          any_one        <= any_one | rx_s;
          bit_idx        <= bit_idx + 3'd1;
          if (bit_idx == LAST_DATA) begin
            state    <= (PARITY != 0) ? PAR : STOP;
            stop_idx <= 1'b0;
          end
        end
        PAR: if (tick) begin
          par_err_q <= (PARITY == 1) ? (par_acc ^ rx_s) : ~(par_acc ^ rx_s);
          any_one   <= any_one | rx_s;
          state     <= STOP;
        end
        STOP: if (tick) begin
          ferr_acc <= ferr_acc | ~rx_s;
          stop_idx <= ~stop_idx;
          if (stop_idx == LAST_STOP) begin
            state     <= IDLE;
            busy      <= 1'b0;
            break_det <= push_brk;
            if (push_ferr) begin
              armed   <= 1'b0;
              arm_cnt <= FULL_BIT;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being freed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[PW-1:0]] <= entry;
  end
endmodule
